// File: rtl/joystick_scan_multi.sv
`default_nettype none
// ============================================================================
// Module   : joystick_scan_multi
// Brief    : Serial scanner for a 74HC165-style chain of NUM_JOY joysticks,
//            BITS_PER_JOY bits each. Produces an active-high packed frame
//            with per-frame valid/changed strobes.
//            Optional debounce: define JOYSCAN_DEBOUNCE_EN to publish a frame
//            only when two consecutive raw frames agree.
// Revision : 1.0 - initial release
// ============================================================================
module joystick_scan_multi #(
    parameter int NUM_JOY      = 2,
    parameter int BITS_PER_JOY = 8,
    parameter int CLK_DIV      = 64,
    parameter int GAP_TICKS    = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              ce,
    output logic                              joyLd,
    output logic                              joyCk,
    input  logic                              joyD,
    output logic [NUM_JOY*BITS_PER_JOY-1:0]   joy,
    output logic                              valid,
    output logic                              changed
);

    localparam int N     = NUM_JOY * BITS_PER_JOY;
    localparam int DIV_W = (CLK_DIV > 1)   ? $clog2(CLK_DIV)       : 1;
    localparam int IDX_W = (N > 1)         ? $clog2(N)             : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    localparam logic [2:0] c_S_LOAD = 3'd0;
    localparam logic [2:0] c_S_SHA  = 3'd1;
    localparam logic [2:0] c_S_SHB  = 3'd2;
    localparam logic [2:0] c_S_PUB  = 3'd3;
    localparam logic [2:0] c_S_GAP  = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [GAP_W-1:0] gap_q,     gap_d;
    logic [N-1:0]     sr_q,      sr_d;
    logic [N-1:0]     joy_q,     joy_d;
    logic             valid_q,   valid_d;
    logic             changed_q, changed_d;
    logic             ld_q,      ld_d;
    logic             ck_q,      ck_d;
`ifdef JOYSCAN_DEBOUNCE_EN
    logic [N-1:0]     raw_q,     raw_d;
`endif

    logic             w_tick;
    logic [N-1:0]     w_sr_shift;

    // Chain data is active-low; the first serial bit ends up in the MSB.
    generate
        if (N > 1) begin : g_sr_wide
            assign w_sr_shift = {sr_q[N-2:0], ~joyD};
        end else begin : g_sr_one
            assign w_sr_shift = ~joyD;
        end
    endgenerate

    assign w_tick = ce && (div_q == c_DIV_LAST);

    // Tick prescaler; frozen during the single-cycle publish state so every
    // phase after it starts from a fresh count.
    always_comb begin
        div_d = div_q;
        if (ce && (state_q != c_S_PUB)) begin
            div_d = w_tick ? '0 : div_q + 1'b1;
        end
    end

    // State register and all other flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= c_S_LOAD;
            div_q     <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            sr_q      <= '0;
            joy_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            ld_q      <= 1'b1;
            ck_q      <= 1'b0;
`ifdef JOYSCAN_DEBOUNCE_EN
            raw_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            sr_q      <= sr_d;
            joy_q     <= joy_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            ld_q      <= ld_d;
            ck_q      <= ck_d;
`ifdef JOYSCAN_DEBOUNCE_EN
            raw_q     <= raw_d;
`endif
        end
    end

    // Next-state logic: every phase is one tick except publish (one ce cycle).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        case (state_q)
            c_S_LOAD: begin
                if (w_tick) begin
                    state_d = c_S_SHA;
                    idx_d   = '0;
                end
            end
            c_S_SHA: begin
                if (w_tick) begin
                    sr_d    = w_sr_shift;
                    state_d = c_S_SHB;
                end
            end
            c_S_SHB: begin
                if (w_tick) begin
                    if (idx_q == c_IDX_LAST) begin
                        state_d = c_S_PUB;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = c_S_SHA;
                    end
                end
            end
            c_S_PUB: begin
                if (ce) begin
                    gap_d   = '0;
                    state_d = (GAP_TICKS == 0) ? c_S_LOAD : c_S_GAP;
                end
            end
            c_S_GAP: begin
                if (w_tick) begin
                    if (gap_q == c_GAP_LAST) begin
                        gap_d   = '0;
                        state_d = c_S_LOAD;
                    end else begin
                        gap_d   = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_S_LOAD;
            end
        endcase
    end

    // Registered outputs: pin levels follow the state, frame published in PUB.
    always_comb begin
        ld_d      = ld_q;
        ck_d      = ck_q;
        valid_d   = valid_q;
        changed_d = changed_q;
        joy_d     = joy_q;
`ifdef JOYSCAN_DEBOUNCE_EN
        raw_d     = raw_q;
`endif
        if (ce) begin
            ld_d      = (state_q != c_S_LOAD);
            ck_d      = (state_q == c_S_SHB);
            valid_d   = (state_q == c_S_PUB);
            changed_d = 1'b0;
            if (state_q == c_S_PUB) begin
`ifdef JOYSCAN_DEBOUNCE_EN
                // Accept the frame only if it matches the previous raw frame.
                raw_d = sr_q;
                if (sr_q == raw_q) begin
                    joy_d     = sr_q;
                    changed_d = (sr_q != joy_q);
                end
`else
                joy_d     = sr_q;
                changed_d = (sr_q != joy_q);
`endif
            end
        end
    end

    assign joyLd   = ld_q;
    assign joyCk   = ck_q;
    assign joy     = joy_q;
    assign valid   = valid_q;
    assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_joystick_scan_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_joystick_scan_multi
// Brief    : Self-checking bench for joystick_scan_multi. Two instances
//            (2/8/4/0 and 1/12/1/3) each drive a behavioural 74HC165 chain;
//            a schedule model predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joystick_scan_multi;

    localparam int NA = 16, DA = 4, GA = 0;
    localparam int FA = (1 + 2*NA + GA) * DA + 1;   // ce cycles per frame
    localparam int PA = (1 + 2*NA) * DA;            // position of publish
    localparam int NB = 12, DB = 1, GB = 3;
    localparam int FB = (1 + 2*NB + GB) * DB + 1;
    localparam int PB = (1 + 2*NB) * DB;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_a, ce_a, ld_a, ck_a, d_a, valid_a, changed_a;
    logic [NA-1:0] joy_a;
    logic          reset_b, ce_b, ld_b, ck_b, d_b, valid_b, changed_b;
    logic [NB-1:0] joy_b;

    joystick_scan_multi #(.NUM_JOY(2), .BITS_PER_JOY(8), .CLK_DIV(DA), .GAP_TICKS(GA)) u_dut_a (
        .clock(clock), .reset(reset_a), .ce(ce_a), .joyLd(ld_a), .joyCk(ck_a),
        .joyD(d_a), .joy(joy_a), .valid(valid_a), .changed(changed_a));

    joystick_scan_multi #(.NUM_JOY(1), .BITS_PER_JOY(12), .CLK_DIV(DB), .GAP_TICKS(GB)) u_dut_b (
        .clock(clock), .reset(reset_b), .ce(ce_b), .joyLd(ld_b), .joyCk(ck_b),
        .joyD(d_b), .joy(joy_b), .valid(valid_b), .changed(changed_b));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected pin levels after the ce cycle at frame position p (-1 = none yet).
    function automatic logic exp_ld(input int p, input int d);
        return !(p >= 0 && p < d);
    endfunction

    function automatic logic exp_ck(input int p, input int d, input int n);
        int q;
        q = p - d;
        if (q < 0 || q >= 2*n*d) return 1'b0;
        return ((q / d) % 2) == 1;
    endfunction

    function automatic logic [NB-1:0] raw_b_of(input int k);
        logic [NB-1:0] one;
        one = 12'h800 >> (k % 12);
        return ~one;
    endfunction

    always @(posedge clock) cyc++;

    // ---------------- chain models (parallel load on joyLd low, shift on joyCk rise)
    logic [NA-1:0] raw_a [0:63];
    int            frame_a = 0;
    logic [NA-1:0] sh_a;
    always @(posedge ck_a or negedge ld_a) begin
        if (!ld_a) sh_a <= raw_a[frame_a & 63];
        else       sh_a <= {sh_a[NA-2:0], 1'b1};
    end
    assign d_a = sh_a[NA-1];

    int            frame_b = 0;
    logic [NB-1:0] sh_b;
    always @(posedge ck_b or negedge ld_b) begin
        if (!ld_b) sh_b <= raw_b_of(frame_b);
        else       sh_b <= {sh_b[NB-2:0], 1'b1};
    end
    assign d_b = sh_b[NB-1];

    // ---------------- behavioural schedule models
    bit            started_a = 1'b0, started_b = 1'b0;
    int            t_a, lp_a = -1, t_b, lp_b = -1;
    logic [NA-1:0] mj_a, mraw_a, mnew_a;
    logic [NB-1:0] mj_b, mraw_b, mnew_b;
    logic          mchg_a, mchg_b;

    always @(posedge clock) begin
        if (reset_a) begin
            started_a = 1'b1; t_a = 0; lp_a = -1; mj_a = '0; mraw_a = '0; mchg_a = 1'b0;
        end else if (ce_a && started_a) begin
            lp_a = t_a % FA;
            if (lp_a == PA) begin
                mnew_a = ~raw_a[frame_a & 63];
`ifdef JOYSCAN_DEBOUNCE_EN
                mchg_a = (mnew_a == mraw_a) && (mnew_a != mj_a);
                if (mnew_a == mraw_a) mj_a = mnew_a;
                mraw_a = mnew_a;
`else
                mchg_a = (mnew_a != mj_a);
                mj_a   = mnew_a;
`endif
                frame_a++;
            end
            t_a++;
        end
    end

    always @(posedge clock) begin
        if (reset_b) begin
            started_b = 1'b1; t_b = 0; lp_b = -1; mj_b = '0; mraw_b = '0; mchg_b = 1'b0;
        end else if (ce_b && started_b) begin
            lp_b = t_b % FB;
            if (lp_b == PB) begin
                mnew_b = ~raw_b_of(frame_b);
`ifdef JOYSCAN_DEBOUNCE_EN
                mchg_b = (mnew_b == mraw_b) && (mnew_b != mj_b);
                if (mnew_b == mraw_b) mj_b = mnew_b;
                mraw_b = mnew_b;
`else
                mchg_b = (mnew_b != mj_b);
                mj_b   = mnew_b;
`endif
                frame_b++;
            end
            t_b++;
        end
    end

    // ---------------- per-cycle compare against the models
    int   ck_rises_a = 0, ld_low_a = 0;
    logic ck_prev_a  = 1'b0;
    always @(negedge clock) begin
        if (started_a) begin
            check("a_joyLd",   32'(ld_a),      32'(exp_ld(lp_a, DA)));
            check("a_joyCk",   32'(ck_a),      32'(exp_ck(lp_a, DA, NA)));
            check("a_valid",   32'(valid_a),   32'(lp_a == PA));
            check("a_changed", 32'(changed_a), 32'((lp_a == PA) && mchg_a));
            check("a_joy",     32'(joy_a),     32'(mj_a));
            if (ck_a && !ck_prev_a) ck_rises_a++;
            if (!ld_a) ld_low_a++;
            ck_prev_a = ck_a;
        end
        if (started_b) begin
            check("b_joyLd",   32'(ld_b),      32'(exp_ld(lp_b, DB)));
            check("b_joyCk",   32'(ck_b),      32'(exp_ck(lp_b, DB, NB)));
            check("b_valid",   32'(valid_b),   32'(lp_b == PB));
            check("b_changed", 32'(changed_b), 32'((lp_b == PB) && mchg_b));
            check("b_joy",     32'(joy_b),     32'(mj_b));
        end
    end

    task automatic wait_valid_a(input string tag);
        int n;
        n = 0;
        while (valid_a && n < 4000)  begin step(); n++; end
        while (!valid_a && n < 4000) begin step(); n++; end
        if (!valid_a) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no valid within %0d cycles, required a frame", tag, n);
        end
    endtask

    // ---------------- instance B: walking zero over 12 frames
    bit done_b = 1'b0;
    initial begin
        int            n, tb_last;
        logic [NB-1:0] w;
        ce_b = 1'b1;
        @(negedge reset_b);
        #1;
        tb_last = 0;
        for (int j = 0; j < 12; j++) begin
            n = 0;
            while (valid_b && n < 200)  begin step(); n++; end
            while (!valid_b && n < 200) begin step(); n++; end
            if (!valid_b) begin
                n_cmp++; n_bad++;
                $display("FAIL b_frame%0d: no valid within %0d cycles, required a frame", j, n);
            end else begin
`ifdef JOYSCAN_DEBOUNCE_EN
                w = '0;
`else
                w = 12'h800 >> j;
`endif
                check("b_walk_joy", 32'(joy_b), 32'(w));
                if (j > 0) check("b_frame_len", 32'(cyc - tb_last), 32'(FB));
                tb_last = cyc;
            end
        end
        done_b = 1'b1;
    end

    // ---------------- instance A: directed then randomized
    initial begin
        int t0, tv, c0, l0;
        reset_a = 1'b1; reset_b = 1'b1; ce_a = 1'b1;
`ifdef JOYSCAN_DEBOUNCE_EN
        raw_a[0] = 16'hFFFF; raw_a[1] = 16'hFFFE; raw_a[2] = 16'hFFFE;
        raw_a[3] = 16'hFFFE; raw_a[4] = 16'hFFFE;
`else
        for (int k = 0; k < 5; k++) raw_a[k] = 16'hFE7F;
`endif
        for (int k = 5; k < 64; k++)
            raw_a[k] = ($urandom_range(0, 1) == 1) ? raw_a[k-1] : 16'($urandom);

        repeat (4) step();
        reset_a = 1'b0; reset_b = 1'b0;
        t0 = cyc; c0 = ck_rises_a; l0 = ld_low_a;

        wait_valid_a("frame1");
        check("first_latency", 32'(cyc - t0), 32'd133);
        check("ck_pulses",     32'(ck_rises_a - c0), 32'd16);
        check("ld_low_clocks", 32'(ld_low_a - l0), 32'd4);
`ifdef JOYSCAN_DEBOUNCE_EN
        check("f1_joy", 32'(joy_a), 32'h0000);
`else
        check("f1_joy", 32'(joy_a), 32'h0180);
        check("f1_changed", 32'(changed_a), 32'd1);
`endif
        tv = cyc;
        wait_valid_a("frame2");
        check("frame_len", 32'(cyc - tv), 32'd133);
`ifdef JOYSCAN_DEBOUNCE_EN
        check("f2_joy", 32'(joy_a), 32'h0000);
`else
        check("f2_joy", 32'(joy_a), 32'h0180);
        check("f2_changed", 32'(changed_a), 32'd0);
`endif
        wait_valid_a("frame3");
`ifdef JOYSCAN_DEBOUNCE_EN
        check("f3_joy", 32'(joy_a), 32'h0001);
        check("f3_changed", 32'(changed_a), 32'd1);
`else
        check("f3_joy", 32'(joy_a), 32'h0180);
`endif

        // Reset while bit 5 is being shifted.
        repeat (48) step();
        reset_a = 1'b1;
        step();
        check("rst_joyLd", 32'(ld_a), 32'd1);
        check("rst_joyCk", 32'(ck_a), 32'd0);
        check("rst_joy",   32'(joy_a), 32'd0);
        reset_a = 1'b0;
        t0 = cyc;
        wait_valid_a("after_reset");
        check("reset_latency", 32'(cyc - t0), 32'd133);
`ifdef JOYSCAN_DEBOUNCE_EN
        check("rst_frame_joy", 32'(joy_a), 32'h0000);
`else
        check("rst_frame_joy", 32'(joy_a), 32'h0180);
        check("rst_frame_changed", 32'(changed_a), 32'd1);
`endif

        // Ten-cycle ce hold in mid-frame stretches the frame by ten clocks.
        tv = cyc;
        repeat (50) step();
        ce_a = 1'b0;
        repeat (10) step();
        ce_a = 1'b1;
        wait_valid_a("ce_hold");
        check("ce_hold_len", 32'(cyc - tv), 32'd143);
`ifdef JOYSCAN_DEBOUNCE_EN
        check("ce_hold_joy", 32'(joy_a), 32'h0001);
`else
        check("ce_hold_joy", 32'(joy_a), 32'h0180);
`endif

        // Random ce gating and random raw frames, checked by the model.
        for (int i = 0; i < 8000 && frame_a < 14; i++) begin
            step();
            ce_a = ($urandom_range(0, 3) != 0);
        end
        ce_a = 1'b1;
        if (frame_a < 14) begin
            n_cmp++; n_bad++;
            $display("FAIL random_frames: got %0d frames required 14", frame_a);
        end

        for (int i = 0; i < 1000 && !done_b; i++) step();
        if (!done_b) begin
            n_cmp++; n_bad++;
            $display("FAIL b_done: instance B got %0d frames required 12", frame_b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
